// File: rtl/turfio_cmd_decode.sv
// turfio_cmd_decode
//   Decodes the 32-bit CIN command stream (aclk domain) into run-control
//   actions, trigger pulses and register-read requests. Read responses come
//   back two cycles after the request. A watchdog flags a silent link, and
//   saturating 16-bit error counters are available for readback.
//
//   Optional build macro: TURFIO_CMD_PARITY_EN
//     When defined, command_i[29] carries odd parity over the whole word.
//     Failing words are discarded and counted in parity_err_cnt. An all-zero
//     word is idle fill: it skips the check but still feeds the watchdog.
//     When undefined, bit 29 is ignored and address 3 reads zero.
//
// Ports:
//   aclk_i            system clock
//   aclk_rstn_i       asynchronous active-low reset
//   command_i         CIN command word
//   command_valid_i   one-cycle qualifier for command_i
//   link_locked_i     CIN parallelizer lock status
//   run_state_o       1 = RUNNING, 0 = IDLE
//   run_reset_o       one-cycle pulse on RUN_RESET
//   trig_valid_o      one-cycle trigger pulse
//   trig_time_o       trigger time field (held between pulses)
//   trig_num_o        trigger sequence number (held between pulses)
//   response_o        read-response word {addr, data[23:0]}
//   response_valid_o  one-cycle qualifier for response_o
//   link_timeout_o    watchdog expired, sticky until the next valid word
module turfio_cmd_decode #(
  parameter int WATCHDOG_CYCLES = 4096,
  parameter int TRIG_NUM_BITS   = 12
) (
  input  logic                     aclk_i,
  input  logic                     aclk_rstn_i,
  input  logic [31:0]              command_i,
  input  logic                     command_valid_i,
  input  logic                     link_locked_i,
  output logic                     run_state_o,
  output logic                     run_reset_o,
  output logic                     trig_valid_o,
  output logic [14:0]              trig_time_o,
  output logic [TRIG_NUM_BITS-1:0] trig_num_o,
  output logic [31:0]              response_o,
  output logic                     response_valid_o,
  output logic                     link_timeout_o
);

  localparam int WD_W = $clog2(WATCHDOG_CYCLES);

  localparam int CNT_DROP   = 0;
  localparam int CNT_BAD_OP = 1;
`ifdef TURFIO_CMD_PARITY_EN
  localparam int CNT_PARITY = 2;
  localparam int NUM_CNT    = 3;
`else
  localparam int NUM_CNT    = 2;
`endif

  typedef enum logic {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  run_state_t               run_state_reg;
  logic                     link_locked_reg;
  logic                     run_reset_reg;
  logic                     trig_valid_reg;
  logic [14:0]              trig_time_reg;
  logic [TRIG_NUM_BITS-1:0] trig_num_out_reg;
  logic [TRIG_NUM_BITS-1:0] trig_cnt_reg;
  logic                     rd_valid_s1_reg;
  logic [31:0]              rd_word_s1_reg;
  logic                     resp_valid_reg;
  logic [31:0]              resp_reg;
  logic [WD_W-1:0]          wd_cnt_reg;
  logic                     timeout_reg;

  // Command qualification
  logic       cmd_accept;
  logic [1:0] opcode;
  logic       is_ctrl, is_trig, is_rdreq, is_bad_op, is_run_reset;
  logic       lock_fall;

`ifdef TURFIO_CMD_PARITY_EN
  logic cmd_is_fill;
  logic parity_fail;
  assign cmd_is_fill = (command_i == 32'h0);
  assign parity_fail = command_valid_i && !cmd_is_fill && !(^command_i);
  assign cmd_accept  = command_valid_i && !parity_fail;
`else
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^command_i[29:15];
  assign cmd_accept      = command_valid_i;
`endif

  assign opcode       = command_i[31:30];
  assign is_ctrl      = cmd_accept && (opcode == 2'b00);
  assign is_trig      = cmd_accept && (opcode == 2'b01);
  assign is_rdreq     = cmd_accept && (opcode == 2'b10);
  assign is_bad_op    = cmd_accept && (opcode == 2'b11);
  assign is_run_reset = is_ctrl && (command_i[1:0] == 2'd1);
  assign lock_fall    = link_locked_reg && !link_locked_i;

  // Saturating 16-bit error counters
  logic [NUM_CNT-1:0] cnt_inc;
  logic [NUM_CNT-1:0] cnt_clr;
  logic [15:0]        err_cnt [NUM_CNT];

  assign cnt_inc[CNT_DROP]   = is_trig && (run_state_reg == IDLE);
  assign cnt_clr[CNT_DROP]   = is_run_reset;
  assign cnt_inc[CNT_BAD_OP] = is_bad_op;
  assign cnt_clr[CNT_BAD_OP] = 1'b0;
`ifdef TURFIO_CMD_PARITY_EN
  assign cnt_inc[CNT_PARITY] = parity_fail;
  assign cnt_clr[CNT_PARITY] = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_err_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge aclk_i or negedge aclk_rstn_i) begin
        if (!aclk_rstn_i)
          cnt_reg <= '0;
        else if (cnt_clr[gi])
          cnt_reg <= '0;
        else if (cnt_inc[gi] && (cnt_reg != 16'hFFFF))
          cnt_reg <= cnt_reg + 16'd1;
      end
      assign err_cnt[gi] = cnt_reg;
    end
  endgenerate

  // Readback data reflects register state as it stood when the request arrived.
  logic [23:0] rd_data;
  always_comb begin
    rd_data = 24'h0;
    case (command_i[7:0])
      8'd0: rd_data = {{(24-TRIG_NUM_BITS){1'b0}}, trig_cnt_reg};
      8'd1: rd_data = {8'h0, err_cnt[CNT_DROP]};
      8'd2: rd_data = {8'h0, err_cnt[CNT_BAD_OP]};
`ifdef TURFIO_CMD_PARITY_EN
      8'd3: rd_data = {8'h0, err_cnt[CNT_PARITY]};
`endif
      8'd4: rd_data = {22'h0, timeout_reg, run_state_reg == RUNNING};
      default: rd_data = 24'h0;
    endcase
  end

  always_ff @(posedge aclk_i or negedge aclk_rstn_i) begin
    if (!aclk_rstn_i) begin
      run_state_reg    <= IDLE;
      link_locked_reg  <= 1'b0;
      run_reset_reg    <= 1'b0;
      trig_valid_reg   <= 1'b0;
      trig_time_reg    <= '0;
      trig_num_out_reg <= '0;
      trig_cnt_reg     <= '0;
      rd_valid_s1_reg  <= 1'b0;
      rd_word_s1_reg   <= '0;
      resp_valid_reg   <= 1'b0;
      resp_reg         <= '0;
      wd_cnt_reg       <= '0;
      timeout_reg      <= 1'b0;
    end else begin
      link_locked_reg <= link_locked_i;
      run_reset_reg   <= is_run_reset;

      // Triggers: only honoured while RUNNING; the count advances per accepted trigger.
      trig_valid_reg <= 1'b0;
      if (is_trig && (run_state_reg == RUNNING)) begin
        trig_valid_reg   <= 1'b1;
        trig_time_reg    <= command_i[14:0];
        trig_num_out_reg <= trig_cnt_reg;
        trig_cnt_reg     <= trig_cnt_reg + TRIG_NUM_BITS'(1);
      end
      if (is_run_reset)
        trig_cnt_reg <= '0;

      // Run state: the command is decoded first, a lock loss overrides it.
      if (is_ctrl) begin
        case (command_i[1:0])
          2'd1:    run_state_reg <= IDLE;
          2'd2:    run_state_reg <= RUNNING;
          2'd3:    run_state_reg <= IDLE;
          default: ;
        endcase
      end
      if (lock_fall)
        run_state_reg <= IDLE;

      // Two-stage read pipeline, no stall.
      rd_valid_s1_reg <= is_rdreq;
      if (is_rdreq)
        rd_word_s1_reg <= {command_i[7:0], rd_data};
      resp_valid_reg <= rd_valid_s1_reg;
      if (rd_valid_s1_reg)
        resp_reg <= rd_word_s1_reg;

      // Watchdog: holds at the terminal count; unlock clears only the count.
      if (cmd_accept) begin
        wd_cnt_reg  <= '0;
        timeout_reg <= 1'b0;
      end else if (!link_locked_i) begin
        wd_cnt_reg <= '0;
      end else if (wd_cnt_reg == WD_W'(WATCHDOG_CYCLES - 1)) begin
        timeout_reg <= 1'b1;
      end else begin
        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
      end
    end
  end

  assign run_state_o      = (run_state_reg == RUNNING);
  assign run_reset_o      = run_reset_reg;
  assign trig_valid_o     = trig_valid_reg;
  assign trig_time_o      = trig_time_reg;
  assign trig_num_o       = trig_num_out_reg;
  assign response_o       = resp_reg;
  assign response_valid_o = resp_valid_reg;
  assign link_timeout_o   = timeout_reg;

endmodule

// File: tb/tb_turfio_cmd_decode.sv
module tb_turfio_cmd_decode;

  localparam int WD  = 64;
  localparam int TNB = 12;

  logic           aclk_i = 1'b0;
  logic           aclk_rstn_i = 1'b0;
  logic [31:0]    command_i = '0;
  logic           command_valid_i = 1'b0;
  logic           link_locked_i = 1'b0;
  logic           run_state_o;
  logic           run_reset_o;
  logic           trig_valid_o;
  logic [14:0]    trig_time_o;
  logic [TNB-1:0] trig_num_o;
  logic [31:0]    response_o;
  logic           response_valid_o;
  logic           link_timeout_o;

  turfio_cmd_decode #(
    .WATCHDOG_CYCLES(WD),
    .TRIG_NUM_BITS  (TNB)
  ) dut (
    .aclk_i          (aclk_i),
    .aclk_rstn_i     (aclk_rstn_i),
    .command_i       (command_i),
    .command_valid_i (command_valid_i),
    .link_locked_i   (link_locked_i),
    .run_state_o     (run_state_o),
    .run_reset_o     (run_reset_o),
    .trig_valid_o    (trig_valid_o),
    .trig_time_o     (trig_time_o),
    .trig_num_o      (trig_num_o),
    .response_o      (response_o),
    .response_valid_o(response_valid_o),
    .link_timeout_o  (link_timeout_o)
  );

  always #5 aclk_i = ~aclk_i;

  int cyc = 0;
  always @(posedge aclk_i) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] val;
    int          at;
  } exp_t;

  exp_t trig_q[$];
  exp_t resp_q[$];

`ifdef TURFIO_CMD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Force odd parity through bit 29 (harmless when parity is disabled).
  function automatic logic [31:0] par(input logic [31:0] w);
    logic [31:0] r;
    r = w & ~32'h2000_0000;
    if (!(^r)) r[29] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge aclk_i);
    #1;
  endtask

  // Present one word for one cycle; e is the index of the edge that sampled it.
  task automatic issue(input logic [31:0] w, output int e);
    command_i       = w;
    command_valid_i = 1'b1;
    step();
    e               = cyc;
    command_valid_i = 1'b0;
    command_i       = '0;
  endtask

  task automatic trig(input logic [14:0] t, input bit fire, input logic [TNB-1:0] n);
    int   e;
    exp_t x;
    issue(par({2'b01, 15'h0, t}), e);
    if (fire) begin
      x.val = {5'h0, n, t};
      x.at  = e;
      trig_q.push_back(x);
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [23:0] d);
    int   e;
    exp_t x;
    issue(par({2'b10, 22'h0, a}), e);
    x.val = {a, d};
    x.at  = e + 1;
    resp_q.push_back(x);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge aclk_i) begin
    exp_t x;
    if (trig_valid_o) begin
      if (trig_q.size() == 0) begin
        total++; bad++;
        $display("FAIL trig_unexpected: got num=%0d time=%h want no pulse", trig_num_o, trig_time_o);
      end else begin
        x = trig_q.pop_front();
        chk("trig_word", {5'h0, trig_num_o, trig_time_o}, x.val);
        chk("trig_cycle", cyc, x.at);
      end
    end else if (trig_q.size() > 0 && trig_q[0].at <= cyc) begin
      x = trig_q.pop_front();
      total++; bad++;
      $display("FAIL trig_missing: got no pulse by cycle %0d want pulse at %0d", cyc, x.at);
    end
    if (response_valid_o) begin
      if (resp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: got %h want no response", response_o);
      end else begin
        x = resp_q.pop_front();
        chk("resp_word", response_o, x.val);
        chk("resp_cycle", cyc, x.at);
      end
    end else if (resp_q.size() > 0 && resp_q[0].at <= cyc) begin
      x = resp_q.pop_front();
      total++; bad++;
      $display("FAIL resp_missing: got no response by cycle %0d want %h at %0d", cyc, x.val, x.at);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish want finish");
    $fatal(1, "time limit");
  end

  initial begin
    int          e;
    logic [31:0] good_w;

    // Reset state
    repeat (3) step();
    chk("rst_run_state", 32'(run_state_o), 32'd0);
    chk("rst_pulses", {29'h0, run_reset_o, trig_valid_o, response_valid_o}, 32'd0);
    chk("rst_trig_fields", {5'h0, trig_num_o, trig_time_o}, 32'd0);
    chk("rst_response", response_o, 32'd0);
    chk("rst_timeout", 32'(link_timeout_o), 32'd0);
    aclk_rstn_i   = 1'b1;
    link_locked_i = 1'b1;
    step();

    // RUN_START then two triggers
    issue(par(32'h0000_0002), e);
    chk("run_start", 32'(run_state_o), 32'd1);
    trig(15'h1234, 1'b1, 12'd0);
    trig(15'h0ABC, 1'b1, 12'd1);

    // IDLE: triggers are dropped and counted
    issue(par(32'h0000_0003), e);
    chk("run_stop", 32'(run_state_o), 32'd0);
    trig(15'h0001, 1'b0, 12'd0);
    trig(15'h0002, 1'b0, 12'd0);
    trig(15'h0003, 1'b0, 12'd0);
    rd(8'd1, 24'h000003);

    // Back-to-back reads
    rd(8'd0, 24'h000002);
    rd(8'd2, 24'h000000);
    rd(8'd4, 24'h000000);
    rd(8'd3, 24'h000000);
    rd(8'd9, 24'h000000);
    repeat (3) step();

    // Lock loss with a trigger in the same cycle: trigger fires, state ends IDLE
    issue(par(32'h0000_0002), e);
    link_locked_i = 1'b0;
    trig(15'h0555, 1'b1, 12'd2);
    chk("lock_loss_idle", 32'(run_state_o), 32'd0);
    repeat (5) step();
    chk("unlocked_no_timeout", 32'(link_timeout_o), 32'd0);

    // Watchdog: expires after exactly WD idle locked cycles
    link_locked_i = 1'b1;
    repeat (WD - 1) step();
    chk("wd_before_limit", 32'(link_timeout_o), 32'd0);
    step();
    chk("wd_at_limit", 32'(link_timeout_o), 32'd1);
    link_locked_i = 1'b0;
    repeat (3) step();
    chk("wd_sticky_unlock", 32'(link_timeout_o), 32'd1);
    link_locked_i = 1'b1;
    issue(par(32'h0000_0000), e);
    chk("wd_nop_clears", 32'(link_timeout_o), 32'd0);

    // RUN_RESET pulse, counters cleared
    issue(par(32'h0000_0001), e);
    chk("run_reset_pulse", 32'(run_reset_o), 32'd1);
    rd(8'd1, 24'h000000);
    chk("run_reset_single", 32'(run_reset_o), 32'd0);
    rd(8'd0, 24'h000000);

    // Sequence number wrap
    issue(par(32'h0000_0002), e);
    for (int i = 0; i < 4095; i++) trig(15'(i), 1'b1, 12'(i));
    trig(15'h7FFF, 1'b1, 12'd4095);
    trig(15'h0001, 1'b1, 12'd0);

    // Bad-opcode saturation
    for (int i = 0; i < 65540; i++) issue(32'hE000_0000, e);
    rd(8'd2, 24'h00FFFF);

    // Parity-violating trigger
    good_w = par(32'h4000_0077);
    issue(good_w ^ 32'h2000_0000, e);
    if (!PAR_EN) begin
      exp_t x;
      x.val = {5'h0, 12'd1, 15'h0077};
      x.at  = e;
      trig_q.push_back(x);
    end
    rd(8'd3, PAR_EN ? 24'h000001 : 24'h000000);
    rd(8'd4, 24'h000001);
    repeat (3) step();

    // Reset mid-operation discards in-flight read and trigger
    issue(par(32'h8000_0000), e);
    issue(par(32'h4000_0011), e);
    aclk_rstn_i = 1'b0;
    repeat (2) step();
    chk("midrst_outputs", {29'h0, trig_valid_o, response_valid_o, run_state_o}, 32'd0);
    aclk_rstn_i = 1'b1;
    repeat (4) step();
    chk("midrst_trig_num", 32'(trig_num_o), 32'd0);
    chk("midrst_resp", response_o, 32'd0);

    chk("trig_q_drained", trig_q.size(), 32'd0);
    chk("resp_q_drained", resp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
